// File: rtl/thumb_fetch_sequencer.sv
// Thumb fetch sequencer: fetches 32-bit words, serves halfwords to the decoder in order.
// Optional stall counter under FETCH_STALL_CNT_EN.
module thumb_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_STALL_CNT_EN
  ,parameter int          CNT_W    = 16
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        hw_valid,
   output logic [15:0] hw_code,
   output logic [31:0] hw_pc,
   input  logic        hw_ready
`ifdef FETCH_STALL_CNT_EN
  ,output logic [CNT_W-1:0] stall_cnt
`endif
);

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   // Cleared by reset so mem_req drops asynchronously and rises one cycle after release.
   logic        run_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC & ~32'd1;
         buf_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      if (flush) begin
         // Redirect wins: a same-cycle ack is dropped and an accept does not advance pc.
         pc_d    = flush_pc & ~32'd1;
         state_d = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (mem_req && mem_ack) begin
                  buf_d   = mem_rdata;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (hw_ready) begin
                  pc_d = pc_q + 32'd2;
                  if (pc_q[1]) state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   assign mem_req  = run_q && (state_q == FETCH);
   assign mem_addr = mem_req ? {pc_q[31:2], 2'b00} : '0;
   assign hw_valid = (state_q == HOLD);
   assign hw_code  = hw_valid ? (pc_q[1] ? buf_q[31:16] : buf_q[15:0]) : '0;
   assign hw_pc    = hw_valid ? pc_q : '0;

`ifdef FETCH_STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (mem_req && hw_ready && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
   end

   assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_thumb_fetch_sequencer.sv
// Directed bench for thumb_fetch_sequencer: per-cycle vector table plus reset/stall-counter sequences.
module tb_thumb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [31:0] flush_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        hw_valid;
   logic [15:0] hw_code;
   logic [31:0] hw_pc;
   logic        hw_ready;
`ifdef FETCH_STALL_CNT_EN
   logic [2:0]  stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

`ifdef FETCH_STALL_CNT_EN
   thumb_fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(3)) dut (
`else
   thumb_fetch_sequencer #(.RESET_PC(32'h0)) dut (
`endif
      .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hw_valid(hw_valid), .hw_code(hw_code), .hw_pc(hw_pc), .hw_ready(hw_ready)
`ifdef FETCH_STALL_CNT_EN
     ,.stall_cnt(stall_cnt)
`endif
   );

   typedef struct {
      logic        flush;
      logic [31:0] fpc;
      logic        ack;
      logic [31:0] rd;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [15:0] code;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(logic f, logic [31:0] fpc, logic ack, logic [31:0] rd, logic rdy,
                               logic req, logic [31:0] addr, logic v, logic [15:0] code,
                               logic [31:0] pc);
      vec_t r;
      r.flush = f; r.fpc = fpc; r.ack = ack; r.rd = rd; r.rdy = rdy;
      r.req = req; r.addr = addr; r.v = v; r.code = code; r.pc = pc;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_outs(input int idx, input logic req, input logic [31:0] addr,
                           input logic v, input logic [15:0] code, input logic [31:0] pc);
      chk("mem_req", idx, {31'd0, mem_req}, {31'd0, req});
      chk("mem_addr", idx, mem_addr, addr);
      chk("hw_valid", idx, {31'd0, hw_valid}, {31'd0, v});
      chk("hw_code", idx, {16'd0, hw_code}, {16'd0, code});
      chk("hw_pc", idx, hw_pc, pc);
   endtask

   initial begin
      // Columns: flush, flush_pc, ack, rdata, ready | req, addr, valid, code, pc (before the edge)
      tbl[0]  = mk(0, 32'h0,        1, 32'hB510_4801, 1, 0, 32'h0,        0, 16'h0,    32'h0);
      tbl[1]  = mk(0, 32'h0,        1, 32'hB510_4801, 1, 1, 32'h0,        0, 16'h0,    32'h0);
      tbl[2]  = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'h4801, 32'h0);
      tbl[3]  = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'hB510, 32'h2);
      tbl[4]  = mk(0, 32'h0,        1, 32'h1111_2222, 0, 1, 32'h4,        0, 16'h0,    32'h0);
      for (int i = 5; i < 10; i++)
         tbl[i] = mk(0, 32'h0,      1, 32'h0,         0, 0, 32'h0,        1, 16'h2222, 32'h4);
      tbl[10] = mk(1, 32'h103,      0, 32'h0,         1, 0, 32'h0,        1, 16'h2222, 32'h4);
      tbl[11] = mk(0, 32'h0,        0, 32'h0,         1, 1, 32'h100,      0, 16'h0,    32'h0);
      tbl[12] = mk(0, 32'h0,        1, 32'hE7FE_BF00, 1, 1, 32'h100,      0, 16'h0,    32'h0);
      tbl[13] = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'hE7FE, 32'h102);
      tbl[14] = mk(1, 32'h200,      1, 32'hDEAD_BEEF, 1, 1, 32'h104,      0, 16'h0,    32'h0);
      tbl[15] = mk(0, 32'h0,        1, 32'h3333_4444, 0, 1, 32'h200,      0, 16'h0,    32'h0);
      tbl[16] = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'h4444, 32'h200);
      tbl[17] = mk(1, 32'hFFFF_FFFC,0, 32'h0,         1, 0, 32'h0,        1, 16'h3333, 32'h202);
      tbl[18] = mk(0, 32'h0,        1, 32'hAAAA_5555, 1, 1, 32'hFFFF_FFFC,0, 16'h0,    32'h0);
      tbl[19] = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'h5555, 32'hFFFF_FFFC);
      tbl[20] = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'hAAAA, 32'hFFFF_FFFE);
      tbl[21] = mk(0, 32'h0,        1, 32'h7777_6666, 1, 1, 32'h0,        0, 16'h0,    32'h0);
      tbl[22] = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'h6666, 32'h0);
      tbl[23] = mk(0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        1, 16'h7777, 32'h2);
      tbl[24] = mk(0, 32'h0,        0, 32'h0,         1, 1, 32'h4,        0, 16'h0,    32'h0);

      rst_n = 1'b0; flush = 1'b0; flush_pc = '0; mem_ack = 1'b0; mem_rdata = '0; hw_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_outs(-1, 0, 32'h0, 0, 16'h0, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         chk_outs(i, tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].code, tbl[i].pc);
         flush = tbl[i].flush; flush_pc = tbl[i].fpc; mem_ack = tbl[i].ack;
         mem_rdata = tbl[i].rd; hw_ready = tbl[i].rdy;
         @(posedge clk);
         @(negedge clk);
      end
      flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

      // Reset asserted in the middle of an outstanding fetch drops the request without a clock.
      chk("pre_rst_req", 0, {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_req", 0, {31'd0, mem_req}, 32'd0);
      chk("rst_addr", 0, mem_addr, 32'h0);
      chk("rst_valid", 0, {31'd0, hw_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_req", 0, {31'd0, mem_req}, 32'd1);
      chk("rel_addr", 0, mem_addr, 32'h0);

`ifdef FETCH_STALL_CNT_EN
      rst_n = 1'b0;
      @(negedge clk);
      chk("stall_rst", 0, {29'd0, stall_cnt}, 32'd0);
      rst_n = 1'b1; hw_ready = 1'b1; mem_ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("stall_4", 0, {29'd0, stall_cnt}, 32'd4);
      flush = 1'b1; flush_pc = 32'h40;
      @(negedge clk);
      flush = 1'b0;
      chk("stall_flush", 0, {29'd0, stall_cnt}, 32'd5);
      repeat (10) @(negedge clk);
      chk("stall_sat", 0, {29'd0, stall_cnt}, 32'd7);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
